// File: rtl/decode_issue.sv
// decode_issue: fetch/decode/execute/mem/writeback sequencer; optional HALT on illegal via DECODE_ISSUE_HALT_EN.
// Latency: R-type 4 cycles, branch 3, illegal 2, SW 4 and LW 5 plus one per mem_ack wait cycle.
// Backpressure: instr_ready only in FETCH; mem_req is held with stable address/data until mem_ack.
module decode_issue #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [31:0]     rf_rd1,
    input  logic [31:0]     rf_rd2,
    output logic [5:0]      alu_opcode,
    output logic [4:0]      alu_shamt,
    output logic [5:0]      alu_funct,
    output logic [31:0]     alu_in1,
    output logic [31:0]     alu_in2,
    input  logic [31:0]     alu_result,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [31:0]     rf_wd,
    output logic            illegal,
    output logic            halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t          state;
    logic [31:0]     instr_q;
    logic [31:0]     rt_dat;

    logic [5:0]      op_q;
    logic [5:0]      fn_q;
    logic [4:0]      rt_q;
    logic [4:0]      rd_q;
    logic [31:0]     imm_sext;
    logic            is_rtype;
    logic            is_lw;
    logic            is_sw;
    logic            is_beq;
    logic            is_bne;
    logic            is_legal;
    logic            br_taken;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;

    assign op_q     = instr_q[31:26];
    assign fn_q     = instr_q[5:0];
    assign rt_q     = instr_q[20:16];
    assign rd_q     = instr_q[15:11];
    assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};

    // Read addresses come straight from the captured word so they are valid throughout DECODE.
    assign rf_ra1 = instr_q[25:21];
    assign rf_ra2 = instr_q[20:16];

    always_comb begin
        is_rtype = 1'b0;
        if (op_q == 6'h00) begin
            case (fn_q)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h02, 6'h00: is_rtype = 1'b1;
                default:                                  is_rtype = 1'b0;
            endcase
        end
    end

    assign is_lw    = (op_q == 6'h23);
    assign is_sw    = (op_q == 6'h2B);
    assign is_beq   = (op_q == 6'h04);
    assign is_bne   = (op_q == 6'h05);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_bne;

    // Branch equality uses the captured operands, not the ALU result.
    assign br_taken = is_beq ? (alu_in1 == rt_dat) : (alu_in1 != rt_dat);
    assign pc_inc   = pc + PC_W'(1);
    assign pc_br    = pc_inc + imm_sext[PC_W-1:0];

`ifdef DECODE_ISSUE_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= '0;
            instr_ready <= 1'b0;
            instr_q     <= '0;
            rt_dat      <= '0;
            alu_opcode  <= '0;
            alu_shamt   <= '0;
            alu_funct   <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rf_we       <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
            illegal     <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                FETCH: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    rt_dat <= rf_rd2;
                    if (is_legal) begin
                        alu_opcode <= instr_q[31:26];
                        alu_shamt  <= instr_q[10:6];
                        alu_funct  <= instr_q[5:0];
                        alu_in1    <= rf_rd1;
                        alu_in2    <= (is_lw || is_sw) ? imm_sext : rf_rd2;
                        state      <= EXEC;
                    end else begin
                        illegal <= 1'b1;
`ifdef DECODE_ISSUE_HALT_EN
                        state   <= HALT;
`else
                        pc          <= pc_inc;
                        instr_ready <= 1'b1;
                        state       <= FETCH;
`endif
                    end
                end
                EXEC: begin
                    if (is_rtype) begin
                        rf_wa <= rd_q;
                        rf_wd <= alu_result;
                        rf_we <= (rd_q != 5'd0);
                        state <= WB;
                    end else if (is_lw || is_sw) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_sw;
                        mem_addr  <= alu_result;
                        mem_wdata <= rt_dat;
                        state     <= MEM;
                    end else begin
                        pc          <= br_taken ? pc_br : pc_inc;
                        instr_ready <= 1'b1;
                        state       <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_lw) begin
                            rf_wa <= rt_q;
                            rf_wd <= mem_rdata;
                            rf_we <= (rt_q != 5'd0);
                            state <= WB;
                        end else begin
                            pc          <= pc_inc;
                            instr_ready <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                WB: begin
                    rf_we       <= 1'b0;
                    pc          <= pc_inc;
                    instr_ready <= 1'b1;
                    state       <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus a randomized program checked against an ISA-level model.
module tb_decode_issue;
    localparam int PC_W = 8;
    localparam int NINSTR = 300;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] pc;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [31:0]     instr = '0;
    logic [4:0]      rf_ra1, rf_ra2;
    logic [31:0]     rf_rd1, rf_rd2;
    logic [5:0]      alu_opcode, alu_funct;
    logic [4:0]      alu_shamt;
    logic [31:0]     alu_in1, alu_in2, alu_result;
    logic            mem_req, mem_we;
    logic [31:0]     mem_addr, mem_wdata;
    logic            mem_ack = 1'b0;
    logic [31:0]     mem_rdata = '0;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [31:0]     rf_wd;
    logic            illegal, halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] regs [32];
    logic [31:0] dmem [logic [31:0]];
    int          ack_delay = 1;
    int          mem_wait = 0;

    // ISA-level model state for the random program
    logic [31:0]     mregs [32];
    logic [31:0]     mdmem [logic [31:0]];
    logic [PC_W-1:0] mpc;
    logic [31:0]     imem [256];
    logic            exp_wr_pend, exp_ill_pend, exp_mem_pend, exp_mwe;
    logic [4:0]      exp_wa;
    logic [31:0]     exp_wd, exp_maddr, exp_mwdata;

    decode_issue #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    always_comb begin
        alu_result = alu_in1 + alu_in2;
        if (alu_opcode == 6'h00) begin
            case (alu_funct)
                6'h22:   alu_result = alu_in1 - alu_in2;
                6'h24:   alu_result = alu_in1 & alu_in2;
                6'h25:   alu_result = alu_in1 | alu_in2;
                6'h02:   alu_result = alu_in2 >> alu_shamt;
                6'h00:   alu_result = alu_in2 << alu_shamt;
                default: alu_result = alu_in1 + alu_in2;
            endcase
        end
    end

    // Register file and data memory: writes at the edge, ack/rdata driven just after it
    always @(posedge clk) begin
        if (rf_we && rf_wa != 5'd0) regs[rf_wa] = rf_wd;
        if (mem_req && mem_ack && mem_we) dmem[mem_addr] = mem_wdata;
        #1;
        if (mem_req) begin
            mem_wait  = mem_wait + 1;
            mem_ack   = (mem_wait >= ack_delay);
            mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : dflt(mem_addr);
        end else begin
            mem_wait = 0;
            mem_ack  = 1'b0;
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        instr_valid = 1'b0;
        ack_delay = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_ready) begin errors++; $display("FAIL ready_timeout got=%0b exp=1", instr_ready); end
    endtask

    // Returns at the negedge of the DECODE cycle (cycle 1)
    task automatic issue(input logic [31:0] w);
        wait_ready();
        instr_valid = 1'b1;
        instr = w;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", instr_ready); end
        checks++; if (mem_req !== 1'b0 || rf_we !== 1'b0 || illegal !== 1'b0 || halted !== 1'b0)
            begin errors++; $display("FAIL reset_ctl got=%0b%0b%0b%0b exp=0000", mem_req, rf_we, illegal, halted); end
        checks++; if (alu_in1 !== '0 || mem_addr !== '0 || rf_wa !== '0)
            begin errors++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", alu_in1, mem_addr, rf_wa); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", instr_ready); end
    endtask

    task automatic test_rtype;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        issue(32'h0022_1820);
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL add_decode_ready got=%0b exp=0", instr_ready); end
        @(negedge clk);
        checks++; if (alu_funct !== 6'h20 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7)
            begin errors++; $display("FAIL add_exec got=%0h/%0h/%0h exp=20/5/7", alu_funct, alu_in1, alu_in2); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'd12)
            begin errors++; $display("FAIL add_wb got=%0b/%0d/%0d exp=1/3/12", rf_we, rf_wa, rf_wd); end
        @(negedge clk);
        checks++; if (pc !== 8'd1 || instr_ready !== 1'b1 || rf_we !== 1'b0)
            begin errors++; $display("FAIL add_next got pc=%0d rdy=%0b we=%0b exp=1/1/0", pc, instr_ready, rf_we); end
        checks++; if (regs[3] !== 32'd12) begin errors++; $display("FAIL add_regfile got=%0d exp=12", regs[3]); end
    endtask

    task automatic test_load_store;
        int n;
        logic stable;
        logic [PC_W-1:0] p;
        regs[1] = 32'h10;
        dmem[32'h0C] = 32'hDEAD_BEEF;
        ack_delay = 3;
        issue(32'h8C24_FFFC);
        @(negedge clk);
        checks++; if (alu_in2 !== 32'hFFFF_FFFC || alu_opcode !== 6'h23)
            begin errors++; $display("FAIL lw_exec got=%0h/%0h exp=fffffffc/23", alu_in2, alu_opcode); end
        @(negedge clk);
        n = 0;
        stable = 1'b1;
        while (mem_req && n < 20) begin
            if (mem_addr !== 32'h0C || mem_we !== 1'b0) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=3", n); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL lw_req_stable got=%0b exp=1", stable); end
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL lw_wb got=%0b/%0d/%0h exp=1/4/deadbeef", rf_we, rf_wa, rf_wd); end
        ack_delay = 1;
        wait_ready();
        p = pc;
        regs[1] = 32'h20;
        regs[2] = 32'h1234;
        issue(32'hAC22_0004);
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'h1234)
            begin errors++; $display("FAIL sw_mem got=%0b/%0b/%0h/%0h exp=1/1/24/1234", mem_req, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        checks++; if (pc !== p + 8'd1 || instr_ready !== 1'b1 || rf_we !== 1'b0)
            begin errors++; $display("FAIL sw_next got pc=%0d rdy=%0b we=%0b exp=%0d/1/0", pc, instr_ready, rf_we, p + 8'd1); end
        checks++; if (!dmem.exists(32'h24) || dmem[32'h24] !== 32'h1234)
            begin errors++; $display("FAIL sw_dmem got=%0b exp=written", dmem.exists(32'h24)); end
    endtask

    task automatic test_branch;
        logic saw;
        do_reset();
        repeat (5) issue(32'h0000_0020);
        wait_ready();
        checks++; if (pc !== 8'd5) begin errors++; $display("FAIL br_setup_pc got=%0d exp=5", pc); end
        regs[1] = 32'd9;
        regs[2] = 32'd9;
        issue(32'h1022_0003);
        saw = rf_we | mem_req;
        repeat (2) begin @(negedge clk); saw = saw | rf_we | mem_req; end
        checks++; if (pc !== 8'd9 || instr_ready !== 1'b1) begin errors++; $display("FAIL beq_taken got pc=%0d rdy=%0b exp=9/1", pc, instr_ready); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL beq_no_write got=%0b exp=0", saw); end
        do_reset();
        repeat (5) issue(32'h0000_0020);
        issue(32'h1422_0003);
        repeat (2) @(negedge clk);
        checks++; if (pc !== 8'd6) begin errors++; $display("FAIL bne_not_taken got=%0d exp=6", pc); end
        do_reset();
        regs[1] = 32'd1;
        regs[2] = 32'd2;
        issue(32'h1422_FFFD);
        repeat (2) @(negedge clk);
        checks++; if (pc !== 8'd254) begin errors++; $display("FAIL bne_back_wrap got=%0d exp=254", pc); end
        issue(32'h0000_0020);
        issue(32'h0000_0020);
        wait_ready();
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL pc_wrap got=%0d exp=0", pc); end
    endtask

    task automatic test_zero_dest;
        logic saw;
        logic [PC_W-1:0] p;
        wait_ready();
        p = pc;
        regs[1] = 32'd3;
        regs[2] = 32'd4;
        issue(32'h0022_0020);
        saw = rf_we;
        repeat (2) begin @(negedge clk); saw = saw | rf_we; end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL zero_wb_ready got=%0b exp=0", instr_ready); end
        @(negedge clk);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL zero_dest_we got=%0b exp=0", saw); end
        checks++; if (pc !== p + 8'd1 || instr_ready !== 1'b1)
            begin errors++; $display("FAIL zero_dest_next got pc=%0d rdy=%0b exp=%0d/1", pc, instr_ready, p + 8'd1); end
    endtask

    task automatic test_illegal;
        logic [PC_W-1:0] p;
        do_reset();
        p = pc;
        issue(32'hFC00_0000);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_early got=%0b exp=0", illegal); end
        @(negedge clk);
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0 || rf_we !== 1'b0)
            begin errors++; $display("FAIL ill_pulse got=%0b/%0b/%0b exp=1/0/0", illegal, mem_req, rf_we); end
`ifdef DECODE_ISSUE_HALT_EN
        checks++; if (halted !== 1'b1 || instr_ready !== 1'b0 || pc !== p)
            begin errors++; $display("FAIL halt_enter got=%0b/%0b/%0d exp=1/0/%0d", halted, instr_ready, pc, p); end
        instr_valid = 1'b1;
        repeat (6) @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (halted !== 1'b1 || instr_ready !== 1'b0 || pc !== p || illegal !== 1'b0)
            begin errors++; $display("FAIL halt_hold got=%0b/%0b/%0d/%0b exp=1/0/%0d/0", halted, instr_ready, pc, illegal, p); end
        do_reset();
        checks++; if (halted !== 1'b0 || instr_ready !== 1'b1)
            begin errors++; $display("FAIL halt_exit got=%0b/%0b exp=0/1", halted, instr_ready); end
`else
        checks++; if (pc !== p + 8'd1 || instr_ready !== 1'b1 || halted !== 1'b0)
            begin errors++; $display("FAIL ill_skip got pc=%0d rdy=%0b h=%0b exp=%0d/1/0", pc, instr_ready, halted, p + 8'd1); end
        @(negedge clk);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got=%0b exp=0", illegal); end
        issue(32'h0022_1821);
        @(negedge clk);
        checks++; if (illegal !== 1'b1 || pc !== p + 8'd2)
            begin errors++; $display("FAIL ill_funct got=%0b/%0d exp=1/%0d", illegal, pc, p + 8'd2); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        regs[1] = 32'h100;
        regs[2] = 32'h55;
        ack_delay = 100;
        issue(32'hAC22_0004);
        n = 0;
        while (!mem_req && n < 10) begin @(negedge clk); n++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got=%0b exp=1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || pc !== '0 || instr_ready !== 1'b0)
            begin errors++; $display("FAIL rmid_abort got=%0b/%0d/%0b exp=0/0/0", mem_req, pc, instr_ready); end
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 1;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1 || dmem.exists(32'h104))
            begin errors++; $display("FAIL rmid_release got rdy=%0b wr=%0b exp=1/0", instr_ready, dmem.exists(32'h104)); end
        regs[1] = 32'd1;
        regs[2] = 32'd1;
        regs[3] = 32'hAAAA;
        issue(32'h0022_1820);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rwb_abort got=%0b exp=0", rf_we); end
        @(negedge clk);
        checks++; if (regs[3] !== 32'hAAAA) begin errors++; $display("FAIL rwb_no_write got=%0h exp=aaaa", regs[3]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fl [6];
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int k;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h02, 6'h00};
        k  = $urandom_range(0, 9);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom_range(0, 32)) - 16'd16;
        case (k)
            4, 9: return {6'h23, rs, rt, imm};
            5:    return {6'h2B, rs, rt, imm};
            6:    return {6'h04, rs, rt, 16'($urandom_range(0, 8)) - 16'd4};
            7:    return {6'h05, rs, rt, 16'($urandom_range(0, 8)) - 16'd4};
`ifndef DECODE_ISSUE_HALT_EN
            8:    return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h21};
`endif
            default: return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fl[$urandom_range(0, 5)]};
        endcase
    endfunction

    // Architectural effect of one instruction, in ISA terms
    task automatic model_exec(input logic [31:0] w);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] a, b, se, v, addr;
        op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6];
        se = {{16{w[15]}}, w[15:0]};
        a = mregs[rs];
        b = mregs[rt];
        ack_delay = $urandom_range(1, 3);
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h02, 6'h00}) begin
            case (fn)
                6'h20:   v = a + b;
                6'h22:   v = a - b;
                6'h24:   v = a & b;
                6'h25:   v = a | b;
                6'h02:   v = b >> sh;
                default: v = b << sh;
            endcase
            if (rd != 5'd0) begin exp_wr_pend = 1'b1; exp_wa = rd; exp_wd = v; mregs[rd] = v; end
            mpc = mpc + 8'd1;
        end else if (op == 6'h23 || op == 6'h2B) begin
            addr = a + se;
            exp_mem_pend = 1'b1;
            exp_maddr = addr;
            exp_mwe = (op == 6'h2B);
            exp_mwdata = b;
            if (op == 6'h2B) mdmem[addr] = b;
            else begin
                v = mdmem.exists(addr) ? mdmem[addr] : dflt(addr);
                if (rt != 5'd0) begin exp_wr_pend = 1'b1; exp_wa = rt; exp_wd = v; mregs[rt] = v; end
            end
            mpc = mpc + 8'd1;
        end else if (op == 6'h04 || op == 6'h05) begin
            mpc = (((op == 6'h04) && (a == b)) || ((op == 6'h05) && (a != b))) ? mpc + 8'd1 + se[7:0] : mpc + 8'd1;
        end else begin
            exp_ill_pend = 1'b1;
            mpc = mpc + 8'd1;
        end
    endtask

    task automatic test_random;
        int accepted = 0;
        int cyc = 0;
        do_reset();
        dmem.delete();
        mdmem.delete();
        for (int i = 0; i < 32; i++) begin
            regs[i] = (i == 0) ? 32'd0 : 32'($urandom_range(0, 63));
            mregs[i] = regs[i];
        end
        for (int i = 0; i < 256; i++) imem[i] = rand_instr();
        mpc = '0;
        exp_wr_pend = 1'b0; exp_ill_pend = 1'b0; exp_mem_pend = 1'b0;
        while (!(accepted >= NINSTR && instr_ready && !exp_wr_pend && !exp_ill_pend && !exp_mem_pend) && cyc < 8000) begin
            if (rf_we) begin
                checks++;
                if (!exp_wr_pend || rf_wa !== exp_wa || rf_wd !== exp_wd) begin
                    errors++; $display("FAIL rnd_wb got=%0d/%0h exp=%0b:%0d/%0h", rf_wa, rf_wd, exp_wr_pend, exp_wa, exp_wd);
                end
                exp_wr_pend = 1'b0;
            end
            if (illegal) begin
                checks++;
                if (!exp_ill_pend) begin errors++; $display("FAIL rnd_illegal got=1 exp=0"); end
                exp_ill_pend = 1'b0;
            end
            if (mem_req && mem_ack) begin
                checks++;
                if (!exp_mem_pend || mem_addr !== exp_maddr || mem_we !== exp_mwe || (exp_mwe && mem_wdata !== exp_mwdata)) begin
                    errors++; $display("FAIL rnd_mem got=%0h/%0b/%0h exp=%0h/%0b/%0h", mem_addr, mem_we, mem_wdata, exp_maddr, exp_mwe, exp_mwdata);
                end
                exp_mem_pend = 1'b0;
            end
            if (instr_ready && accepted < NINSTR && $urandom_range(0, 3) != 0) begin
                checks++;
                if (exp_wr_pend || exp_ill_pend || exp_mem_pend || pc !== mpc) begin
                    errors++; $display("FAIL rnd_fetch got pc=%0d pend=%0b%0b%0b exp=%0d/000", pc, exp_wr_pend, exp_ill_pend, exp_mem_pend, mpc);
                end
                instr_valid = 1'b1;
                instr = imem[mpc];
                model_exec(imem[mpc]);
                accepted++;
            end else begin
                instr_valid = instr_ready ? 1'b0 : 1'($urandom_range(0, 1));
                instr = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        checks++; if (cyc >= 8000) begin errors++; $display("FAIL rnd_timeout got=%0d exp<8000", accepted); end
        checks++; if (pc !== mpc) begin errors++; $display("FAIL rnd_final_pc got=%0d exp=%0d", pc, mpc); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (regs[i] !== mregs[i]) begin errors++; $display("FAIL rnd_reg%0d got=%0h exp=%0h", i, regs[i], mregs[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_zero_dest();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
